// File: rtl/print_stream_packer_if.sv
// Word stream leaving the packer: one packed console word plus its valid-byte count.
// A word transfers on a clock edge where val_out && ready_downward; the master keeps
// dout/dout_bytes stable while val_out is high and ready_downward is low.
interface print_stream_packer_if;
  logic [31:0] dout;
  logic [2:0]  dout_bytes;
  logic        val_out;
  logic        ready_downward;

  modport master (
    output dout,
    output dout_bytes,
    output val_out,
    input  ready_downward
  );

  modport slave (
    input  dout,
    input  dout_bytes,
    input  val_out,
    output ready_downward
  );
endinterface

// File: rtl/print_stream_packer.sv
// Packs console chars from the core's print_out port little-endian into 32-bit words
// and queues them in a first-word-fall-through FIFO; overflowing words are dropped and counted.
module print_stream_packer #(
  parameter int         DEPTH      = 16,
  parameter int         ADDR_BITS  = 4,
  parameter logic [7:0] FLUSH_CHAR = 8'h0A,
  parameter int         TIMEOUT    = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [48:0]            print_in,
  print_stream_packer_if.master  out_if,
  output logic                   overflow,
  output logic [15:0]            drop_count,
  output logic                   pack_state_dbg
);

  localparam int IDLE_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam int PW      = ADDR_BITS + 1;

  typedef enum logic [0:0] {S_EMPTY = 1'b0, S_PARTIAL = 1'b1} pack_state_e;

  pack_state_e       state;
  logic [31:0]       pack_reg;
  logic [1:0]        byte_cnt;
  logic [IDLE_W-1:0] idle_cnt;

  logic        char_v;
  logic [7:0]  ch;
  logic        unused_print_bits;
  logic [31:0] merged;
  logic        timeout_hit;
  logic        push;
  logic [34:0] push_entry;

  assign char_v            = print_in[48];
  assign ch                = print_in[7:0];
  assign unused_print_bits = ^print_in[47:8];
  assign pack_state_dbg    = state;

  // A char always beats the idle timeout, so at most one push source fires per cycle.
  always_comb begin
    merged      = pack_reg | ({24'd0, ch} << {byte_cnt, 3'b000});
    timeout_hit = (TIMEOUT != 0) && (state == S_PARTIAL) && !char_v &&
                  (idle_cnt == IDLE_W'(TO_LAST));
    push        = 1'b0;
    push_entry  = '0;
    if (char_v && ((byte_cnt == 2'd3) || (ch == FLUSH_CHAR))) begin
      push       = 1'b1;
      push_entry = {{1'b0, byte_cnt} + 3'd1, merged};
    end else if (timeout_hit) begin
      push       = 1'b1;
      push_entry = {1'b0, byte_cnt, pack_reg};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_EMPTY;
      pack_reg <= '0;
      byte_cnt <= '0;
      idle_cnt <= '0;
    end else if (char_v) begin
      idle_cnt <= '0;
      if (push) begin
        state    <= S_EMPTY;
        pack_reg <= '0;
        byte_cnt <= '0;
      end else begin
        state    <= S_PARTIAL;
        pack_reg <= merged;
        byte_cnt <= byte_cnt + 2'd1;
      end
    end else if (timeout_hit) begin
      state    <= S_EMPTY;
      pack_reg <= '0;
      byte_cnt <= '0;
      idle_cnt <= '0;
    end else if (state == S_PARTIAL) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  logic [34:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          empty;
  logic          full;
  logic          pop;
  logic          accept;
  logic          drop;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[ADDR_BITS-1:0] == rd_ptr[ADDR_BITS-1:0]) &&
                  (wr_ptr[ADDR_BITS] != rd_ptr[ADDR_BITS]);
  assign pop    = !empty && out_if.ready_downward;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr[ADDR_BITS-1:0]] <= push_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
    end
  end

  assign out_if.val_out = !empty;
  assign {out_if.dout_bytes, out_if.dout} = empty ? 35'd0 : mem[rd_ptr[ADDR_BITS-1:0]];

endmodule
